// File: rtl/nn_vec_collector_pkg.sv
// Shared types and sizing helpers for the NN output vector collector.
package nn_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    REPLAY  = 1'b1
  } collect_state_t;

  localparam int DEF_M  = 8;
  localparam int DEF_T  = 16;
  localparam int DEF_IW = $clog2(DEF_M);

  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/nn_vec_collector_argmax_track.sv
// Running argmax candidate; max_val/argmax present the candidate including the
// element being accepted this cycle, so the parent can commit it on the last accept.
module nn_argmax_track
  import nn_pkg::*;
#(
  parameter int T = DEF_T,
  parameter int M = DEF_M,
  localparam int IW = idx_width(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          first,
  input  logic          en,
  input  logic [T-1:0]  data_in,
  input  logic [IW-1:0] idx,
  output logic [T-1:0]  max_val,
  output logic [IW-1:0] argmax
);

  logic [T-1:0]  cand_val_r;
  logic [IW-1:0] cand_idx_r;
  logic [T-1:0]  nxt_val_s;
  logic [IW-1:0] nxt_idx_s;

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    nxt_val_s = cand_val_r;
    nxt_idx_s = cand_idx_r;
    if (en && (first || ($signed(data_in) > $signed(cand_val_r)))) begin
      nxt_val_s = data_in;
      nxt_idx_s = idx;
    end else begin
      nxt_val_s = cand_val_r;
      nxt_idx_s = cand_idx_r;
    end
  end

  // Candidate registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_val_r <= {T{1'b0}};
      cand_idx_r <= {IW{1'b0}};
    end else begin
      cand_val_r <= nxt_val_s;
      cand_idx_r <= nxt_idx_s;
    end
  end

  assign max_val = nxt_val_s;
  assign argmax  = nxt_idx_s;

endmodule

// File: rtl/nn_vec_collector.sv
// Collects an M-element signed vector, then replays it on a master stream.
// Optional argmax tracking is enabled with NN_COLLECT_ARGMAX_EN.
module nn_vec_collector
  import nn_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int T = DEF_T,
  localparam int IW = idx_width(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [T-1:0]  data_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [T-1:0]  data_out,
  output logic          m_last,
  output logic          res_valid,
  output logic [T-1:0]  max_val,
  output logic [IW-1:0] argmax
);

  localparam logic [IW-1:0] LAST_IDX   = IW'(M - 1);
  localparam logic [IW-1:0] PENULT_IDX = IW'(M - 2);

  collect_state_t state_r;
  logic [IW-1:0]  wr_idx_r;
  logic [IW-1:0]  rd_idx_r;
  logic [T-1:0]   vec_buf_r [M];
  logic           accept_s;
  logic           emit_s;

  assign accept_s = s_valid && s_ready;
  assign emit_s   = m_valid && m_ready;

  // Element storage; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      vec_buf_r[wr_idx_r] <= data_in;
    end
  end

  assign data_out = m_valid ? vec_buf_r[rd_idx_r] : {T{1'b0}};

  // Collect/replay sequencing; handshake flags are registered state decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= COLLECT;
      wr_idx_r <= {IW{1'b0}};
      rd_idx_r <= {IW{1'b0}};
      s_ready  <= 1'b1;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            if (wr_idx_r == LAST_IDX) begin
              wr_idx_r <= {IW{1'b0}};
              state_r  <= REPLAY;
              s_ready  <= 1'b0;
              m_valid  <= 1'b1;
              m_last   <= 1'b0;
            end else begin
              wr_idx_r <= wr_idx_r + IW'(1);
            end
          end
        end
        REPLAY: begin
          if (emit_s) begin
            if (rd_idx_r == LAST_IDX) begin
              rd_idx_r <= {IW{1'b0}};
              state_r  <= COLLECT;
              s_ready  <= 1'b1;
              m_valid  <= 1'b0;
              m_last   <= 1'b0;
            end else begin
              rd_idx_r <= rd_idx_r + IW'(1);
              m_last   <= (rd_idx_r == PENULT_IDX);
            end
          end
        end
        default: begin
          state_r  <= COLLECT;
          wr_idx_r <= {IW{1'b0}};
          rd_idx_r <= {IW{1'b0}};
          s_ready  <= 1'b1;
          m_valid  <= 1'b0;
          m_last   <= 1'b0;
        end
      endcase
    end
  end

`ifdef NN_COLLECT_ARGMAX_EN
  logic          first_s;
  logic          last_accept_s;
  logic [T-1:0]  cand_val_s;
  logic [IW-1:0] cand_idx_s;
  logic          res_valid_r;
  logic [T-1:0]  max_val_r;
  logic [IW-1:0] argmax_r;

  assign first_s       = (wr_idx_r == {IW{1'b0}});
  assign last_accept_s = accept_s && (wr_idx_r == LAST_IDX);

  nn_argmax_track #(.T(T), .M(M)) u_track (
    .clk     (clk),
    .reset   (reset),
    .first   (first_s),
    .en      (accept_s),
    .data_in (data_in),
    .idx     (wr_idx_r),
    .max_val (cand_val_s),
    .argmax  (cand_idx_s)
  );

  // Commit on the M-th accept; res_valid drops when the next vector begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_r <= 1'b0;
      max_val_r   <= {T{1'b0}};
      argmax_r    <= {IW{1'b0}};
    end else if (last_accept_s) begin
      res_valid_r <= 1'b1;
      max_val_r   <= cand_val_s;
      argmax_r    <= cand_idx_s;
    end else if (accept_s && first_s) begin
      res_valid_r <= 1'b0;
    end
  end

  assign res_valid = res_valid_r;
  assign max_val   = max_val_r;
  assign argmax    = argmax_r;
`else
  assign res_valid = 1'b0;
  assign max_val   = {T{1'b0}};
  assign argmax    = {IW{1'b0}};
`endif

endmodule

// File: tb/tb_nn_vec_collector.sv
// Randomized self-checking bench for nn_vec_collector; expected results come
// from a plain array/argmax model of the vector.
module tb_nn_vec_collector;

  localparam int M  = 8;
  localparam int T  = 16;
  localparam int IW = 3;
`ifdef NN_COLLECT_ARGMAX_EN
  localparam bit ARG_EN = 1'b1;
`else
  localparam bit ARG_EN = 1'b0;
`endif

  typedef logic [T-1:0] vec_t [M];

  logic          clk = 1'b0;
  logic          reset, s_valid, s_ready, m_valid, m_ready, m_last, res_valid;
  logic [T-1:0]  data_in, data_out, max_val;
  logic [IW-1:0] argmax;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent run_vec call.
  vec_t          got;
  int            got_n, last_bad, stall_bad, overlap_bad, extra_acc, cycles;
  bit            timeout;
  logic          rv_start, rv_after_first, rv_at_mv;
  logic [T-1:0]  max_at_mv;
  logic [IW-1:0] arg_at_mv;

  always #5 clk = ~clk;

  nn_vec_collector #(.M(M), .T(T)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out), .m_last(m_last),
    .res_valid(res_valid), .max_val(max_val), .argmax(argmax)
  );

  // Reference: largest signed element, lowest index on ties; zero when disabled.
  function automatic void model_max(input vec_t v, output logic [T-1:0] mv, output int mi);
    mv = v[0];
    mi = 0;
    for (int i = 1; i < M; i++) begin
      if ($signed(v[i]) > $signed(mv)) begin
        mv = v[i];
        mi = i;
      end
    end
    if (!ARG_EN) begin
      mv = '0;
      mi = 0;
    end
  endfunction

  // Streams one vector in and drains its replay, recording what was observed.
  task automatic run_vec(input vec_t v, input int gap_pct, input int rdy_pct, input bit hold);
    int sent, recv;
    bit prev_stall, pend_first, mv_seen;
    logic [T-1:0] prev_data;
    sent = 0; recv = 0; prev_stall = 0; pend_first = 0; mv_seen = 0; prev_data = '0;
    last_bad = 0; stall_bad = 0; overlap_bad = 0; extra_acc = 0; cycles = 0; timeout = 0;
    rv_start = 1'bx; rv_after_first = 1'bx; rv_at_mv = 1'bx; max_at_mv = 'x; arg_at_mv = 'x;
    while (recv < M) begin
      if (cycles >= 2000) begin
        timeout = 1;
        break;
      end
      @(negedge clk);
      cycles++;
      if (cycles == 1) rv_start = res_valid;
      if (pend_first) begin
        rv_after_first = res_valid;
        pend_first = 0;
      end
      if (m_valid === 1'b1 && !mv_seen) begin
        mv_seen = 1; rv_at_mv = res_valid; max_at_mv = max_val; arg_at_mv = argmax;
      end
      if (prev_stall && (m_valid !== 1'b1 || data_out !== prev_data)) stall_bad++;
      if (m_valid === s_ready) overlap_bad++;
      if (m_valid === 1'b1) begin
        if (m_last !== (recv == M - 1)) last_bad++;
      end else if (m_last !== 1'b0) begin
        last_bad++;
      end
      if (sent < M) begin
        s_valid = ($urandom_range(99) >= gap_pct);
        data_in = s_valid ? v[sent] : T'($urandom);
      end else begin
        s_valid = hold;
        data_in = T'($urandom);
      end
      m_ready = ($urandom_range(99) < rdy_pct);
      if (s_valid && s_ready === 1'b1) begin
        if (sent < M) begin
          if (sent == 0) pend_first = 1;
          sent++;
        end else begin
          extra_acc++;
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        got[recv] = data_out;
        recv++;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = data_out;
    end
    got_n = recv;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b1)  begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_last !== 1'b0)   begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if (max_val !== '0)    begin errors++; $display("FAIL reset_max_val got %h exp 0", max_val); end
    checks++; if (argmax !== '0)     begin errors++; $display("FAIL reset_argmax got %0d exp 0", argmax); end
    checks++; if (data_out !== '0)   begin errors++; $display("FAIL reset_data_out got %h exp 0", data_out); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    vec_t v; logic [T-1:0] mv; int mi;
    v = '{16'sd10, -16'sd3, 16'sd7, 16'sd42, 16'sd0, 16'sd5, -16'sd100, 16'sd1};
    model_max(v, mv, mi);
    run_vec(v, 0, 100, 1'b0);
    checks++; if (timeout || got_n != M) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_n, M); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got[i] !== v[i]) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, got[i], v[i]); end
    end
    checks++; if (last_bad != 0) begin errors++; $display("FAIL basic_m_last bad cycles %0d exp 0", last_bad); end
    checks++; if (max_at_mv !== mv) begin errors++; $display("FAIL basic_max got %h exp %h", max_at_mv, mv); end
    checks++; if (arg_at_mv !== IW'(mi)) begin errors++; $display("FAIL basic_argmax got %0d exp %0d", arg_at_mv, mi); end
    checks++; if (rv_at_mv !== ARG_EN) begin errors++; $display("FAIL basic_res_valid got %b exp %b", rv_at_mv, ARG_EN); end
    checks++; if (cycles != 2 * M) begin errors++; $display("FAIL basic_period got %0d exp %0d", cycles, 2 * M); end
  endtask

  task automatic test_ties();
    vec_t v; logic [T-1:0] mv; int mi;
    v = '{-16'sd5, -16'sd2, -16'sd2, -16'sd9, -16'sd2, -16'sd7, -16'sd8, -16'sd6};
    model_max(v, mv, mi);
    run_vec(v, 20, 70, 1'b0);
    checks++; if (timeout || got_n != M) begin errors++; $display("FAIL ties_count got %0d exp %0d", got_n, M); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got[i] !== v[i]) begin errors++; $display("FAIL ties_data[%0d] got %h exp %h", i, got[i], v[i]); end
    end
    checks++; if (max_at_mv !== mv) begin errors++; $display("FAIL ties_max got %h exp %h", max_at_mv, mv); end
    checks++; if (arg_at_mv !== IW'(mi)) begin errors++; $display("FAIL ties_argmax got %0d exp %0d", arg_at_mv, mi); end
  endtask

  task automatic test_backpressure();
    vec_t v; logic [T-1:0] mv; int mi;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < M; i++) v[i] = T'($urandom);
      model_max(v, mv, mi);
      run_vec(v, 0, 30, 1'b0);
      checks++; if (timeout || got_n != M) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_n, M); end
      for (int i = 0; i < got_n; i++) begin
        checks++; if (got[i] !== v[i]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, got[i], v[i]); end
      end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable bad cycles %0d exp 0", stall_bad); end
      checks++; if (overlap_bad != 0) begin errors++; $display("FAIL bp_ready_valid_excl bad cycles %0d exp 0", overlap_bad); end
      checks++; if (last_bad != 0) begin errors++; $display("FAIL bp_m_last bad cycles %0d exp 0", last_bad); end
      checks++; if (max_at_mv !== mv || arg_at_mv !== IW'(mi)) begin
        errors++; $display("FAIL bp_result got %h/%0d exp %h/%0d", max_at_mv, arg_at_mv, mv, mi);
      end
    end
  endtask

  task automatic test_gaps();
    vec_t v; logic [T-1:0] mv; int mi;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < M; i++) v[i] = T'($urandom);
      model_max(v, mv, mi);
      run_vec(v, 45, 60, 1'b1);
      checks++; if (timeout || got_n != M) begin errors++; $display("FAIL gaps_count got %0d exp %0d", got_n, M); end
      for (int i = 0; i < got_n; i++) begin
        checks++; if (got[i] !== v[i]) begin errors++; $display("FAIL gaps_data[%0d] got %h exp %h", i, got[i], v[i]); end
      end
      checks++; if (extra_acc != 0) begin errors++; $display("FAIL gaps_replay_accepts got %0d exp 0", extra_acc); end
      checks++; if (max_at_mv !== mv || arg_at_mv !== IW'(mi)) begin
        errors++; $display("FAIL gaps_result got %h/%0d exp %h/%0d", max_at_mv, arg_at_mv, mv, mi);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v; logic [T-1:0] mv; int mi; int total;
    for (int i = 0; i < M; i++) v[i] = T'($urandom);
    run_vec(v, 0, 100, 1'b0);
    total = cycles;
    for (int i = 0; i < M; i++) v[i] = T'($urandom);
    model_max(v, mv, mi);
    run_vec(v, 0, 100, 1'b0);
    total += cycles;
    checks++; if (timeout || got_n != M) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_n, M); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got[i] !== v[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got[i], v[i]); end
    end
    checks++; if (total != 4 * M) begin errors++; $display("FAIL b2b_cycles got %0d exp %0d", total, 4 * M); end
    checks++; if (rv_start !== ARG_EN) begin errors++; $display("FAIL b2b_rv_hold got %b exp %b", rv_start, ARG_EN); end
    checks++; if (rv_after_first !== 1'b0) begin errors++; $display("FAIL b2b_rv_drop got %b exp 0", rv_after_first); end
    checks++; if (max_at_mv !== mv || arg_at_mv !== IW'(mi) || rv_at_mv !== ARG_EN) begin
      errors++; $display("FAIL b2b_result got %h/%0d/%b exp %h/%0d/%b", max_at_mv, arg_at_mv, rv_at_mv, mv, mi, ARG_EN);
    end
  endtask

  task automatic test_reset_mid_replay();
    vec_t v; logic [T-1:0] mv; int mi; int hs; int guard;
    for (int i = 0; i < M; i++) v[i] = T'($urandom);
    for (int i = 0; i < M; i++) begin
      @(negedge clk);
      s_valid = 1'b1; data_in = v[i]; m_ready = 1'b0;
    end
    hs = 0; guard = 0;
    while (hs < 3 && guard < 50) begin
      @(negedge clk);
      guard++;
      s_valid = 1'b0; m_ready = 1'b1;
      if (m_valid === 1'b1) hs++;
    end
    checks++; if (hs != 3) begin errors++; $display("FAIL rmr_handshakes got %0d exp 3", hs); end
    @(negedge clk);
    reset = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmr_s_ready got %b exp 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmr_m_valid got %b exp 0", m_valid); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rmr_res_valid got %b exp 0", res_valid); end
    reset = 1'b0;
    for (int i = 0; i < M; i++) v[i] = T'($urandom);
    model_max(v, mv, mi);
    run_vec(v, 10, 80, 1'b0);
    checks++; if (timeout || got_n != M) begin errors++; $display("FAIL rmr_count got %0d exp %0d", got_n, M); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got[i] !== v[i]) begin errors++; $display("FAIL rmr_data[%0d] got %h exp %h", i, got[i], v[i]); end
    end
    checks++; if (max_at_mv !== mv || arg_at_mv !== IW'(mi)) begin
      errors++; $display("FAIL rmr_result got %h/%0d exp %h/%0d", max_at_mv, arg_at_mv, mv, mi);
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_reset_mid_replay();
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
